// File: rtl/regfile_write_port.sv
// Write side of the general-purpose register file: an in-order write-back FIFO
// draining one entry per cycle into the register array, plus a registered read port.
module regfile_write_port #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_index,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       wr_be,
    input  logic [2:0]       rd_index,
    output logic [WIDTH-1:0] rd_val,
    output logic             rd_pending,
    output logic             idle,
    output logic [7:0]       commit_cnt
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] r_regs     [NREGS];
    logic [2:0]       r_fifoIdx  [DEPTH];
    logic [WIDTH-1:0] r_fifoData [DEPTH];
    logic [1:0]       r_fifoBe   [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rdVal;
    logic             r_rdPending;
    logic [7:0]       r_commitCnt;

    logic             w_push;
    logic             w_pop;
    logic             w_pendHit;
    logic [2:0]       w_headIdx;
    logic [WIDTH-1:0] w_headData;
    logic [1:0]       w_headBe;

    assign wr_ready   = !rst && (r_count < CW'(DEPTH));
    assign idle       = (r_count == '0);
    assign w_push     = wr_valid && wr_ready;
    assign w_pop      = (r_count != '0);
    assign w_headIdx  = r_fifoIdx[r_head];
    assign w_headData = r_fifoData[r_head];
    assign w_headBe   = r_fifoBe[r_head];

    assign rd_val     = r_rdVal;
    assign rd_pending = r_rdPending;
    assign commit_cnt = r_commitCnt;

    // A slot is occupied when its distance from the head is below the count;
    // the head being committed this edge still counts as pending.
    always_comb begin
        w_pendHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(PW'(PW'(i) - r_head)) < r_count) && (r_fifoIdx[i] == rd_index)) begin
                w_pendHit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_rdVal     <= '0;
            r_rdPending <= 1'b0;
            r_commitCnt <= '0;
        end else begin
            // Read samples the array before this edge's commit: no write-through.
            r_rdVal     <= r_regs[rd_index];
            r_rdPending <= w_pendHit;

            if (w_push) begin
                r_fifoIdx[r_tail]  <= wr_index;
                r_fifoData[r_tail] <= wr_data;
                r_fifoBe[r_tail]   <= wr_be;
                r_tail             <= r_tail + PW'(1);
            end

            if (w_pop) begin
                if (w_headBe[1]) begin
                    r_regs[w_headIdx][WIDTH-1:HALF] <= w_headData[WIDTH-1:HALF];
                end
                if (w_headBe[0]) begin
                    r_regs[w_headIdx][HALF-1:0] <= w_headData[HALF-1:0];
                end
                r_head      <= r_head + PW'(1);
                r_commitCnt <= r_commitCnt + 8'd1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port: a behavioural model predicts each edge's
// read/commit outputs into a scoreboard queue that is drained after the edge.
module tb_regfile_write_port;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_index;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [2:0]  rd_index;
    logic [15:0] rd_val;
    logic        rd_pending;
    logic        idle;
    logic [7:0]  commit_cnt;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] data;
        logic [1:0]  be;
    } entry_t;

    typedef struct {
        logic [15:0] val;
        logic        pend;
        logic [7:0]  cnt;
    } exp_t;

    logic [15:0] mRegs [8];
    entry_t      mFifo [$];
    exp_t        expQ  [$];
    logic [7:0]  mCnt;
    int          checks;
    int          errors;

    regfile_write_port #(.WIDTH(16), .NREGS(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_index(wr_index), .wr_data(wr_data), .wr_be(wr_be),
        .rd_index(rd_index), .rd_val(rd_val), .rd_pending(rd_pending),
        .idle(idle), .commit_cnt(commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle: check combinational outputs, predict the edge, then compare after it.
    task automatic applyStimulus(input logic r, input logic v, input logic [2:0] idx,
                                 input logic [15:0] data, input logic [1:0] be,
                                 input logic [2:0] ri);
        exp_t   e;
        entry_t h;
        logic   readyNow;
        rst = r; wr_valid = v; wr_index = idx; wr_data = data; wr_be = be; rd_index = ri;
        #1;
        readyNow = !r && (mFifo.size() < 4);
        checkOutput("wr_ready", wr_ready, readyNow);
        checkOutput("idle", idle, mFifo.size() == 0);
        if (r) begin
            foreach (mRegs[k]) mRegs[k] = '0;
            mFifo.delete();
            mCnt = '0;
            e.val = '0; e.pend = 1'b0; e.cnt = '0;
        end else begin
            e.val  = mRegs[ri];
            e.pend = 1'b0;
            foreach (mFifo[k]) if (mFifo[k].idx == ri) e.pend = 1'b1;
            if (mFifo.size() > 0) begin
                h = mFifo.pop_front();
                if (h.be[1]) mRegs[h.idx][15:8] = h.data[15:8];
                if (h.be[0]) mRegs[h.idx][7:0]  = h.data[7:0];
                mCnt = mCnt + 8'd1;
            end
            if (v && readyNow) mFifo.push_back('{idx, data, be});
            e.cnt = mCnt;
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput("rd_val", rd_val, e.val);
        checkOutput("rd_pending", rd_pending, e.pend);
        checkOutput("commit_cnt", commit_cnt, e.cnt);
    endtask

    task automatic idleRead(input logic [2:0] ri);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, ri);
    endtask

    initial begin
        checks = 0; errors = 0; mCnt = '0;
        foreach (mRegs[k]) mRegs[k] = '0;
        rst = 1'b1; wr_valid = 1'b0; wr_index = '0; wr_data = '0; wr_be = '0; rd_index = '0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 3'd0);
        applyStimulus(1'b1, 1'b1, 3'd1, 16'hFFFF, 2'b11, 3'd1);

        for (int i = 0; i < 8; i++) idleRead(3'(i));

        // Single full write, then watch pending and read-back latency.
        applyStimulus(1'b0, 1'b1, 3'd3, 16'hBEEF, 2'b11, 3'd3);
        idleRead(3'd3);
        checkOutput("pend_k1", rd_pending, 1'b1);
        checkOutput("idle_k1", idle, 1'b1);
        idleRead(3'd3);
        checkOutput("val_k2", rd_val, 16'hBEEF);
        checkOutput("cnt_single", commit_cnt, 8'd1);

        // Half writes to idx 5, then an all-disabled write.
        applyStimulus(1'b0, 1'b1, 3'd5, 16'h1234, 2'b11, 3'd5);
        applyStimulus(1'b0, 1'b1, 3'd5, 16'hAB00, 2'b10, 3'd5);
        applyStimulus(1'b0, 1'b1, 3'd5, 16'h00CD, 2'b01, 3'd5);
        applyStimulus(1'b0, 1'b1, 3'd5, 16'h5555, 2'b00, 3'd5);
        idleRead(3'd5);
        idleRead(3'd5);
        checkOutput("half_merge", rd_val, 16'hABCD);
        checkOutput("cnt_be00", commit_cnt, 8'd5);

        // Same-index writes resolve to the last accepted.
        applyStimulus(1'b0, 1'b1, 3'd2, 16'h0001, 2'b11, 3'd2);
        applyStimulus(1'b0, 1'b1, 3'd2, 16'h0002, 2'b11, 3'd2);
        applyStimulus(1'b0, 1'b1, 3'd2, 16'h0003, 2'b11, 3'd2);
        idleRead(3'd2);
        idleRead(3'd2);
        checkOutput("last_wins", rd_val, 16'h0003);

        // Reset with a write still queued discards it.
        applyStimulus(1'b0, 1'b1, 3'd6, 16'h7777, 2'b11, 3'd6);
        applyStimulus(1'b1, 1'b1, 3'd7, 16'h8888, 2'b11, 3'd6);
        for (int i = 0; i < 8; i++) idleRead(3'(i));
        checkOutput("cnt_after_rst", commit_cnt, 8'd0);

        // Long stream to wrap the commit counter.
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b0, 1'b1, 3'(i % 8), 16'(i), 2'b11, 3'((i * 3) % 8));
        idleRead(3'd0);
        for (int i = 0; i < 8; i++) idleRead(3'(i));
        checkOutput("cnt_wrap", commit_cnt, 8'd44);
        idleRead(3'd3);
        checkOutput("reg3_299", rd_val, 16'd299);

        // Random traffic against the model.
        for (int i = 0; i < 150; i++)
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          16'($urandom), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
